// File: rtl/ptc_sar_tracker.sv
// ptc_sar_tracker: SAR delay-code search for the FMDLL, with optional +/-1 LSB tracking and lock detect.
// Build option: define PTC_TRACK_EN to include the tracking states; otherwise the block idles after the search.
module ptc_sar_tracker #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned COARSE_BITS = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned LOCK_COUNT  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      comp,
  output logic [WIDTH-1:0]          q,
  output logic [2**COARSE_BITS-1:0] therm,
  output logic [2**COARSE_BITS-1:0] therm_b,
  output logic                      pd_reset,
  output logic                      busy,
  output logic                      done,
  output logic                      locked
);

  localparam int unsigned THERM_W = 2**COARSE_BITS;
  localparam int unsigned IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [WIDTH-1:0] Q_MID = WIDTH'(1) << (WIDTH - 1);

  if (WIDTH < COARSE_BITS + 1 || HOLD_CYCLES < 1 || LOCK_COUNT < 1) begin : g_param_check
    $error("ptc_sar_tracker: invalid parameter set");
  end

`ifdef PTC_TRACK_EN
  localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECIDE,
    ST_TRACK_SETTLE,
    ST_TRACK_DECIDE
  } state_t;

  logic [LOCK_W-1:0] rev_cnt;
  logic              last_dir;
  logic              last_valid;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECIDE
  } state_t;
`endif

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              settle_last;
  logic              restart;

  assign settle_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  // A start is honoured when idle, and also aborts tracking; it is ignored mid-search.
`ifdef PTC_TRACK_EN
  assign restart = start && (state == ST_IDLE || state == ST_TRACK_SETTLE ||
                             state == ST_TRACK_DECIDE);
`else
  assign restart = start && (state == ST_IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      q          <= '0;
      hold_cnt   <= '0;
      bit_idx    <= IDX_W'(WIDTH - 1);
      pd_reset   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
`ifdef PTC_TRACK_EN
      rev_cnt    <= '0;
      last_dir   <= 1'b0;
      last_valid <= 1'b0;
`endif
    end else begin
      pd_reset <= 1'b0;
      done     <= 1'b0;
      if (restart) begin
        q          <= Q_MID;
        bit_idx    <= IDX_W'(WIDTH - 1);
        hold_cnt   <= '0;
        locked     <= 1'b0;
        busy       <= 1'b1;
        pd_reset   <= 1'b1;
        state      <= ST_SETTLE;
`ifdef PTC_TRACK_EN
        rev_cnt    <= '0;
        last_valid <= 1'b0;
`endif
      end else begin
        case (state)
          ST_SETTLE: begin
            if (settle_last) begin
              hold_cnt <= '0;
              state    <= ST_DECIDE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end

          ST_DECIDE: begin
            if (!comp) q[bit_idx] <= 1'b0;
            if (bit_idx != '0) begin
              q[bit_idx - 1'b1] <= 1'b1;
              bit_idx           <= bit_idx - 1'b1;
              pd_reset          <= 1'b1;
              state             <= ST_SETTLE;
            end else begin
              done <= 1'b1;
              busy <= 1'b0;
`ifdef PTC_TRACK_EN
              pd_reset <= 1'b1;
              state    <= ST_TRACK_SETTLE;
`else
              locked   <= 1'b1;
              state    <= ST_IDLE;
`endif
            end
          end

`ifdef PTC_TRACK_EN
          ST_TRACK_SETTLE: begin
            if (settle_last) begin
              hold_cnt <= '0;
              state    <= ST_TRACK_DECIDE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end

          ST_TRACK_DECIDE: begin
            if (comp) begin
              if (q != '1) q <= q + 1'b1;
            end else begin
              if (q != '0) q <= q - 1'b1;
            end
            last_dir   <= comp;
            last_valid <= 1'b1;
            // Lock is raised on the same edge that brings the reversal count to its limit.
            if (last_valid) begin
              if (comp != last_dir) begin
                if (rev_cnt != LOCK_W'(LOCK_COUNT)) rev_cnt <= rev_cnt + 1'b1;
                if (rev_cnt >= LOCK_W'(LOCK_COUNT - 1)) locked <= 1'b1;
              end else begin
                rev_cnt <= '0;
                locked  <= 1'b0;
              end
            end
            pd_reset <= 1'b1;
            state    <= ST_TRACK_SETTLE;
          end
`endif

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic [COARSE_BITS-1:0] coarse;

  always_comb begin
    coarse = q[WIDTH-1 -: COARSE_BITS];
    therm  = '0;
    for (int unsigned k = 0; k < THERM_W; k++) begin
      therm[k] = (k < 32'(coarse));
    end
  end

  assign therm_b = ~therm;

endmodule

// File: tb/tb_ptc_sar_tracker.sv
// Directed self-checking bench for ptc_sar_tracker at default parameters.
// Expectations follow the PTC_TRACK_EN build option when it is defined.
module tb_ptc_sar_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        comp;
  logic [9:0]  q;
  logic [15:0] therm;
  logic [15:0] therm_b;
  logic        pd_reset;
  logic        busy;
  logic        done;
  logic        locked;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pd_cnt   = 0;
  int unsigned done_cnt = 0;
  int          comp_mode = 0;  // 0: q<=600, 1: stuck 1, 2: stuck 0, 3: toggle

`ifdef PTC_TRACK_EN
  localparam int unsigned PD_AT_DONE = 1;
`else
  localparam int unsigned PD_AT_DONE = 0;
`endif

  int unsigned sar_seq [10] = '{768, 640, 576, 608, 592, 600, 604, 602, 601, 600};

  ptc_sar_tracker #(
    .WIDTH       (10),
    .COARSE_BITS (4),
    .HOLD_CYCLES (4),
    .LOCK_COUNT  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .comp     (comp),
    .q        (q),
    .therm    (therm),
    .therm_b  (therm_b),
    .pd_reset (pd_reset),
    .busy     (busy),
    .done     (done),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    case (comp_mode)
      0:       comp = (q <= 10'd600);
      1:       comp = 1'b1;
      2:       comp = 1'b0;
      default: comp = ~comp;
    endcase
    if (pd_reset) pd_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called at the negedge of the first SETTLE cycle; returns cycles until done is seen.
  task automatic run_to_done(input int start_at, output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      start = (start_at >= 0 && cyc == start_at);
      tick();
      cyc++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic rst_mid_search();
    int unsigned d0;
    int          cyc;
    comp_mode = 0;
    do_start();
    repeat (12) tick();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_async_q", q, 0);
    check("rst_async_therm_b", therm_b, 16'hFFFF);
    check("rst_async_busy", busy, 0);
    check("rst_async_flags", {pd_reset, done, locked}, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (60) tick();
    check("rst_no_done", done_cnt, d0);
    check("rst_idle_q", q, 0);
    do_start();
    check("restart_q", q, 512);
    run_to_done(-1, cyc);
    check("restart_cycles", cyc, 50);
    check("restart_q_final", q, 600);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    comp  = 1'b0;
    repeat (3) tick();
    check("reset_q", q, 0);
    check("reset_therm", therm, 16'h0000);
    check("reset_therm_b", therm_b, 16'hFFFF);
    check("reset_flags", {pd_reset, busy, done, locked}, 0);
    rst = 1'b0;
    tick();

    // Main SAR walk towards 600
    comp_mode = 0;
    pd_cnt    = 0;
    done_cnt  = 0;
    do_start();
    check("sar_first_q", q, 512);
    check("sar_first_busy", busy, 1);
    check("sar_first_pd", pd_reset, 1);
    for (int k = 0; k < 10; k++) begin
      repeat (5) tick();
      check($sformatf("sar_q_dec%0d", k + 1), q, sar_seq[k]);
    end
    check("sar_done_pulse", done, 1);
    check("sar_done_count", done_cnt, 1);
    check("sar_pd_count", pd_cnt, 10 + PD_AT_DONE);
    check("sar_busy_end", busy, 0);
    check("sar_therm", therm, 16'h01FF);
    check("sar_therm_b", therm_b, 16'hFE00);

`ifdef PTC_TRACK_EN
    check("trk_locked_at_done", locked, 0);
    for (int n = 1; n <= 10; n++) begin
      repeat (5) tick();
      check($sformatf("trk_q_dec%0d", n), q, (n % 2 == 1) ? 601 : 600);
      if (n <= 8) check($sformatf("trk_unlocked_dec%0d", n), locked, 0);
    end
    check("trk_locked", locked, 1);
    check("trk_done_once", done_cnt, 1);
    comp_mode = 1;
    repeat (10) tick();
    check("trk_force_q", q, 602);
    check("trk_force_unlock", locked, 0);
    comp_mode = 0;
    repeat (60) tick();
    check("trk_relock", locked, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("trk_abort_locked", locked, 0);
    check("trk_abort_q", q, 512);
    check("trk_abort_busy", busy, 1);
    run_to_done(-1, cyc);
    check("trk_abort_cycles", cyc, 50);
    check("trk_abort_q_final", q, 600);

    // Stuck-high comparator with an ignored start at bit 5
    comp_mode = 1;
    do_start();
    run_to_done(21, cyc);
    check("stuck1_cycles", cyc, 50);
    check("stuck1_q", q, 1023);
    repeat (25) tick();
    check("stuck1_track_q", q, 1023);
    check("stuck1_locked", locked, 0);

    comp_mode = 2;
    do_start();
    run_to_done(-1, cyc);
    check("stuck0_cycles", cyc, 50);
    check("stuck0_q", q, 0);
    repeat (25) tick();
    check("stuck0_track_q", q, 0);
    check("stuck0_locked", locked, 0);
`else
    check("idle_locked_at_done", locked, 1);
    comp_mode = 3;
    repeat (20) tick();
    check("idle_locked_hold", locked, 1);
    check("idle_q_hold", q, 600);
    check("idle_busy", busy, 0);
    check("idle_done_once", done_cnt, 1);

    // Stuck-high comparator with an ignored start at bit 5
    comp_mode = 1;
    do_start();
    check("stuck1_locked_clr", locked, 0);
    run_to_done(21, cyc);
    check("stuck1_cycles", cyc, 50);
    check("stuck1_q", q, 1023);
    repeat (10) tick();
    check("stuck1_q_hold", q, 1023);
    check("stuck1_locked", locked, 1);

    comp_mode = 2;
    do_start();
    run_to_done(-1, cyc);
    check("stuck0_cycles", cyc, 50);
    check("stuck0_q", q, 0);
    repeat (10) tick();
    check("stuck0_q_hold", q, 0);

    do_start();
    check("next_start_locked", locked, 0);
    check("next_start_q", q, 512);
    check("next_start_busy", busy, 1);
    repeat (3) tick();
`endif

    rst_mid_search();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
